game_tick_gen: RTL

Multi-channel programmable tick generator for the game logic. It derives up to CHANNELS independent slow timebases from clk_in, for example player movement, meteor fall rate and spawn rate. Each channel provides a one-cycle strobe and a 50%-duty square wave. Each channel's divisor can be reloaded at runtime, so difficulty can ramp without re-synthesis. A global enable pauses every channel at once, for game-over and menu screens.

---
 rtl/game_tick_gen.sv | 90 +++++++++
 1 files changed

// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator: per-channel one-cycle strobe and square wave.
// Optional feature: define GAME_TICK_RESYNC_EN to add the resync input for phase alignment.
module game_tick_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 19,
    parameter int DEFAULT_DIV = 131071,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
`ifdef GAME_TICK_RESYNC_EN
    input  logic                resync,
`endif
    input  logic                enable,
    input  logic                load,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [CNT_W-1:0]    load_div,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] game_clk,
    output logic                any_tick
);

    logic [CNT_W-1:0]    r_cnt [CHANNELS];
    logic [CNT_W-1:0]    r_div [CHANNELS];
    logic [CHANNELS-1:0] r_tick;
    logic [CHANNELS-1:0] r_gameClk;
    logic                r_anyTick;

    logic [CNT_W-1:0]    w_cntNext [CHANNELS];
    logic [CNT_W-1:0]    w_divNext [CHANNELS];
    logic [CHANNELS-1:0] w_tickNext;
    logic [CHANNELS-1:0] w_gameClkNext;
    logic                w_resync;

`ifdef GAME_TICK_RESYNC_EN
    assign w_resync = resync;
`else
    assign w_resync = 1'b0;
`endif

    // Select values beyond CHANNELS-1 never match any channel index, so such loads are ignored.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_cntNext[i]     = r_cnt[i];
            w_divNext[i]     = r_div[i];
            w_tickNext[i]    = 1'b0;
            w_gameClkNext[i] = r_gameClk[i];
            if (w_resync) begin
                w_cntNext[i]     = '0;
                w_gameClkNext[i] = 1'b0;
            end else if (load && (load_ch == CH_W'(i))) begin
                w_divNext[i] = load_div;
                w_cntNext[i] = '0;
            end else if (enable) begin
                if (r_cnt[i] == r_div[i]) begin
                    w_cntNext[i]     = '0;
                    w_tickNext[i]    = 1'b1;
                    w_gameClkNext[i] = ~r_gameClk[i];
                end else begin
                    w_cntNext[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
                r_div[i] <= CNT_W'(DEFAULT_DIV);
            end
            r_tick    <= '0;
            r_gameClk <= '0;
            r_anyTick <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= w_cntNext[i];
                r_div[i] <= w_divNext[i];
            end
            r_tick    <= w_tickNext;
            r_gameClk <= w_gameClkNext;
            r_anyTick <= |w_tickNext;
        end
    end

    assign tick     = r_tick;
    assign game_clk = r_gameClk;
    assign any_tick = r_anyTick;

endmodule
